// File: rtl/adder_bist.sv
// adder_bist: exhaustive built-in self test for a WIDTH-bit adder.
// It walks every (op_a, op_b) pair, holds each pair for MAX_COUNT cycles and
// compares {dut_cout, dut_sum} against op_a + op_b on the last cycle of that
// window. Mismatches are counted in err_count, which saturates at 255.
// Optional feature: define ADDER_BIST_FAIL_CAPTURE_EN to latch the operands
// of the first mismatch in a run (fail_valid/fail_a/fail_b). When it is not
// defined those outputs are tied to zero.
module adder_bist #(
  parameter int unsigned WIDTH     = 3,
  parameter int unsigned MAX_COUNT = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count,
  output logic             fail_valid,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b
);

  localparam int unsigned IW = 2 * WIDTH;
  localparam logic [IW-1:0] LAST_INDEX = '1;
  localparam logic [15:0] PACE_LAST = 16'(MAX_COUNT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [IW-1:0] r_index;
  logic [15:0]   r_pace;
  logic [7:0]    r_err;
  logic          r_busy;
  logic          r_done;
  logic          r_pass;

  logic [WIDTH:0] w_expected;
  logic           w_mismatch;
  logic           w_sample;
  logic           w_launch;
  logic [7:0]     w_err_next;

  // Operands are simply the halves of the registered vector index.
  assign op_a      = r_index[IW-1:WIDTH];
  assign op_b      = r_index[WIDTH-1:0];
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err;

  // Reference result and compare/strobe decoding.
  always_comb begin
    w_expected = {1'b0, op_a} + {1'b0, op_b};
    w_mismatch = ({dut_cout, dut_sum} != w_expected);
    w_sample   = (r_state == S_RUN) && (r_pace == PACE_LAST);
    w_launch   = (r_state != S_RUN) && start;
    w_err_next = r_err;
    if (w_mismatch && (r_err != 8'hFF)) begin
      w_err_next = r_err + 8'd1;
    end
  end

  // Control FSM: vector walk, pacing, error count and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_index <= '0;
      r_pace  <= '0;
      r_err   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_RUN;
            r_index <= '0;
            r_pace  <= '0;
            r_err   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_sample) begin
            r_err <= w_err_next;
            if (r_index == LAST_INDEX) begin
              // Verdict uses the count including the last vector's result.
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_err_next == 8'd0);
            end else begin
              r_index <= r_index + 1'b1;
              r_pace  <= '0;
            end
          end else begin
            r_pace <= r_pace + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ADDER_BIST_FAIL_CAPTURE_EN
  logic             r_fail_valid;
  logic [WIDTH-1:0] r_fail_a;
  logic [WIDTH-1:0] r_fail_b;

  assign fail_valid = r_fail_valid;
  assign fail_a     = r_fail_a;
  assign fail_b     = r_fail_b;

  // First-mismatch capture; cleared on each new run, never overwritten within one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fail_valid <= 1'b0;
      r_fail_a     <= '0;
      r_fail_b     <= '0;
    end else if (w_launch) begin
      r_fail_valid <= 1'b0;
      r_fail_a     <= '0;
      r_fail_b     <= '0;
    end else if (w_sample && w_mismatch && !r_fail_valid) begin
      r_fail_valid <= 1'b1;
      r_fail_a     <= op_a;
      r_fail_b     <= op_b;
    end
  end
`else
  assign fail_valid = 1'b0;
  assign fail_a     = '0;
  assign fail_b     = '0;
`endif

endmodule
